// File: rtl/mem_reader_if.sv
// RAM read port plus valid/ready byte stream used by mem_reader.
// master = reader side, slave = RAM / downstream sink side.
`timescale 1ns/1ps
interface mem_reader_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
);
   logic                  r_en;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_data;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;

   modport master (
      output r_en,
      output r_addr,
      input  r_data,
      output out_data,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  r_en,
      input  r_addr,
      output r_data,
      input  out_data,
      input  out_valid,
      output out_ready
   );
endinterface

// File: rtl/mem_reader.sv
// Walks RAM addresses START_ADDR..END_ADDR and streams each byte out over valid/ready.
// Optional continuous looping with a stop request: define MEM_READER_LOOP_EN.
`timescale 1ns/1ps
module mem_reader #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8,
   parameter int START_ADDR = 0,
   parameter int END_ADDR   = 15
) (
   input  logic         clk,
   input  logic         rst_btn,
   input  logic         start,
`ifdef MEM_READER_LOOP_EN
   input  logic         stop,
`endif
   output logic         busy,
   output logic         done,
   mem_reader_if.master bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      WAIT = 2'd2,
      SEND = 2'd3
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] START_A = ADDR_WIDTH'(START_ADDR);
   localparam logic [ADDR_WIDTH-1:0] END_A   = ADDR_WIDTH'(END_ADDR);
   localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);

   state_t                state_r;
   state_t                state_nxt_s;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic [ADDR_WIDTH-1:0] addr_nxt_s;
   logic [ADDR_WIDTH-1:0] addr_inc_s;
   logic                  busy_r;
   logic                  busy_nxt_s;
   logic                  done_r;
   logic                  done_nxt_s;
   logic                  r_en_r;
   logic                  r_en_nxt_s;
   logic [ADDR_WIDTH-1:0] r_addr_r;
   logic [ADDR_WIDTH-1:0] r_addr_nxt_s;
   logic [DATA_WIDTH-1:0] out_data_r;
   logic [DATA_WIDTH-1:0] out_data_nxt_s;
   logic                  out_valid_r;
   logic                  out_valid_nxt_s;
   logic                  xfer_s;
   logic                  last_s;

   // Valid is always high in SEND, so a transfer is SEND with ready.
   assign xfer_s = (state_r == SEND) && bus.out_ready;

`ifdef MEM_READER_LOOP_EN
   logic stop_pend_r;
   logic stop_pend_nxt_s;

   // A stop seen in the transfer cycle itself ends the sequence on that transfer.
   assign last_s     = stop_pend_r || stop;
   assign addr_inc_s = (addr_r == END_A) ? START_A : (addr_r + ONE_A);

   // Sticky stop request, dropped once back in IDLE.
   always_comb begin
      stop_pend_nxt_s = stop_pend_r;
      if (state_r == IDLE) begin
         stop_pend_nxt_s = 1'b0;
      end else if (busy_r && stop) begin
         stop_pend_nxt_s = 1'b1;
      end else begin
         stop_pend_nxt_s = stop_pend_r;
      end
   end

   // Stop-request register.
   always_ff @(posedge clk or negedge rst_btn) begin
      if (!rst_btn) begin
         stop_pend_r <= 1'b0;
      end else begin
         stop_pend_r <= stop_pend_nxt_s;
      end
   end
`else
   assign last_s     = (addr_r == END_A);
   assign addr_inc_s = addr_r + ONE_A;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_btn) begin
      if (!rst_btn) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nxt_s = READ;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         READ: state_nxt_s = WAIT;
         WAIT: state_nxt_s = SEND;
         SEND: begin
            if (xfer_s) begin
               state_nxt_s = last_s ? IDLE : READ;
            end else begin
               state_nxt_s = SEND;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Next values for the registered outputs and the address counter.
   always_comb begin
      addr_nxt_s      = addr_r;
      busy_nxt_s      = busy_r;
      done_nxt_s      = 1'b0;
      r_addr_nxt_s    = r_addr_r;
      out_data_nxt_s  = out_data_r;
      out_valid_nxt_s = out_valid_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               addr_nxt_s   = START_A;
               r_addr_nxt_s = START_A;
               busy_nxt_s   = 1'b1;
            end else begin
               addr_nxt_s   = addr_r;
               r_addr_nxt_s = r_addr_r;
               busy_nxt_s   = busy_r;
            end
         end
         READ: begin
            out_valid_nxt_s = 1'b0;
         end
         WAIT: begin
            out_data_nxt_s  = bus.r_data;
            out_valid_nxt_s = 1'b1;
         end
         SEND: begin
            if (xfer_s) begin
               out_valid_nxt_s = 1'b0;
               if (last_s) begin
                  busy_nxt_s = 1'b0;
                  done_nxt_s = 1'b1;
               end else begin
                  addr_nxt_s   = addr_inc_s;
                  r_addr_nxt_s = addr_inc_s;
               end
            end else begin
               out_valid_nxt_s = 1'b1;
            end
         end
         default: begin
            busy_nxt_s      = 1'b0;
            out_valid_nxt_s = 1'b0;
         end
      endcase
   end

   // r_en is registered on entry to READ so it is high for exactly that cycle.
   assign r_en_nxt_s = (state_nxt_s == READ);

   // Output and address registers.
   always_ff @(posedge clk or negedge rst_btn) begin
      if (!rst_btn) begin
         addr_r      <= START_A;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         r_en_r      <= 1'b0;
         r_addr_r    <= {ADDR_WIDTH{1'b0}};
         out_data_r  <= {DATA_WIDTH{1'b0}};
         out_valid_r <= 1'b0;
      end else begin
         addr_r      <= addr_nxt_s;
         busy_r      <= busy_nxt_s;
         done_r      <= done_nxt_s;
         r_en_r      <= r_en_nxt_s;
         r_addr_r    <= r_addr_nxt_s;
         out_data_r  <= out_data_nxt_s;
         out_valid_r <= out_valid_nxt_s;
      end
   end

   assign busy          = busy_r;
   assign done          = done_r;
   assign bus.r_en      = r_en_r;
   assign bus.r_addr    = r_addr_r;
   assign bus.out_data  = out_data_r;
   assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_mem_reader.sv
// Self-checking bench for mem_reader: RAM model with mem[i] = A0 + i, a byte-stream
// scoreboard built from the address walk, and directed sequences.
`timescale 1ns/1ps
module tb_mem_reader;
   localparam int AW = 4;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst_btn = 1'b0;
   logic start = 1'b0;
   logic start_w = 1'b0;
   logic busy, done, busy_w, done_w;
`ifdef MEM_READER_LOOP_EN
   logic stop = 1'b0;
   logic stop_w = 1'b0;
`endif

   int tests_run = 0;
   int tests_failed = 0;

   mem_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
   mem_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_w ();

   mem_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .START_ADDR(0), .END_ADDR(15)) dut (
      .clk(clk), .rst_btn(rst_btn), .start(start),
`ifdef MEM_READER_LOOP_EN
      .stop(stop),
`endif
      .busy(busy), .done(done), .bus(bus.master)
   );

   mem_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .START_ADDR(14), .END_ADDR(1)) dut_w (
      .clk(clk), .rst_btn(rst_btn), .start(start_w),
`ifdef MEM_READER_LOOP_EN
      .stop(stop_w),
`endif
      .busy(busy_w), .done(done_w), .bus(bus_w.master)
   );

   always #5 clk = ~clk;

   // RAM model with a registered read port
   logic [7:0] mem [16];
   initial for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);
   always @(posedge clk) if (bus.r_en) bus.r_data <= mem[bus.r_addr];
   always @(posedge clk) if (bus_w.r_en) bus_w.r_data <= mem[bus_w.r_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model: the i-th byte of a walk starting at start_a
   function automatic logic [7:0] model_byte(input int start_a, input int i);
      return 8'hA0 + 8'((start_a + i) % 16);
   endfunction

   function automatic int model_len(input int start_a, input int end_a);
      return ((end_a - start_a + 16) % 16) + 1;
   endfunction

   logic [7:0] exp_q[$];
   int xfer_cnt = 0, done_cnt = 0, cyc = 0, last_xfer_cyc = 0;
   bit check_gap = 0;
   logic [7:0] first_byte, last_byte;

   // Per-cycle compare of the main DUT against the scoreboard
   initial begin
      logic       prev_stall;
      logic [7:0] prev_data;
      prev_stall = 1'b0;
      prev_data  = 8'h00;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_btn) begin
            prev_stall = 1'b0;
            exp_q.delete();
         end else begin
            if (prev_stall) begin
               check("hold_valid", 32'(bus.out_valid), 32'd1);
               check("hold_data", 32'(bus.out_data), 32'(prev_data));
            end
            if (bus.r_en) check("r_en_while_busy", 32'(busy), 32'd1);
            if (bus.out_valid && bus.out_ready) begin
               if (exp_q.size() == 0) begin
                  tests_run++;
                  tests_failed++;
                  $display("FAIL extra_byte: got %0h expected none", bus.out_data);
               end else begin
                  check("byte", 32'(bus.out_data), 32'(exp_q.pop_front()));
               end
               if (check_gap && xfer_cnt > 0) check("byte_gap", 32'(cyc - last_xfer_cyc), 32'd3);
               if (xfer_cnt == 0) first_byte = bus.out_data;
               last_byte = bus.out_data;
               last_xfer_cyc = cyc;
               xfer_cnt++;
            end
            if (done) begin
               check("done_busy_low", 32'(busy), 32'd0);
               check("done_queue_empty", 32'(exp_q.size()), 32'd0);
               done_cnt++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
         end
      end
   end

   // Collector for the wrapping-range DUT
   logic [7:0] got_w[$];
   int done_w_cnt = 0;
   initial forever begin
      @(negedge clk);
      if (rst_btn && bus_w.out_valid && bus_w.out_ready) got_w.push_back(bus_w.out_data);
      if (done_w) done_w_cnt++;
   end

   // One full sequence; mode 0 = ready held high, 1 = ready toggling
   task automatic run_seq(input int mode, input bit poke_start, input bit measure, input int n_bytes);
      int d0;
      int budget;
      for (int i = 0; i < n_bytes; i++) exp_q.push_back(model_byte(0, i));
      xfer_cnt  = 0;
      d0        = done_cnt;
      check_gap = (mode == 0);
      bus.out_ready = 1'b1;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      if (measure) begin
         check("lat_r_en", 32'(bus.r_en), 32'd1);
         check("lat_r_addr", 32'(bus.r_addr), 32'd0);
         check("lat_busy", 32'(busy), 32'd1);
         @(posedge clk); #1;
         check("wait_r_en_low", 32'(bus.r_en), 32'd0);
         check("wait_valid_low", 32'(bus.out_valid), 32'd0);
         @(posedge clk); #1;
         check("lat_valid", 32'(bus.out_valid), 32'd1);
         check("lat_first_data", 32'(bus.out_data), 32'hA0);
      end
      budget = 0;
`ifdef MEM_READER_LOOP_EN
      while (done_cnt == d0 && budget < 600) begin
         @(posedge clk); #1;
         budget++;
         stop = (xfer_cnt == 20) && (stop == 1'b0) && (exp_q.size() == 1);
      end
      stop = 1'b0;
`else
      while (done_cnt == d0 && budget < 600) begin
         @(posedge clk); #1;
         budget++;
         if (mode == 1) bus.out_ready = budget[0];
         start = poke_start && (budget == 10 || budget == 25);
      end
      start = 1'b0;
`endif
      if (done_cnt == d0) begin
         tests_run++;
         tests_failed++;
         $display("FAIL done_timeout: got no done expected one within 600 cycles");
      end
      bus.out_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check("byte_count", 32'(xfer_cnt), 32'(n_bytes));
      check("done_count", 32'(done_cnt - d0), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_valid", 32'(bus.out_valid), 32'd0);
      check("idle_keep_data", 32'(bus.out_data), 32'(model_byte(0, n_bytes - 1)));
   endtask

   initial begin
      int d0;
      int budget;
      bus.out_ready   = 1'b0;
      bus_w.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_r_en", 32'(bus.r_en), 32'd0);
      check("rst_r_addr", 32'(bus.r_addr), 32'd0);
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_data", 32'(bus.out_data), 32'd0);
      rst_btn = 1'b1;
      repeat (2) @(posedge clk);

`ifdef MEM_READER_LOOP_EN
      // Loop mode: A0..AF, A0..A3, one more byte, then done
      run_seq(0, 1'b0, 1'b1, 21);
      check("loop_last_byte", 32'(last_byte), 32'hA4);
`else
      // Test 1: ready high, A0..AF one every 3 cycles
      run_seq(0, 1'b0, 1'b1, 16);
      check("t1_first_byte", 32'(first_byte), 32'hA0);
      check("t1_last_byte", 32'(last_byte), 32'hAF);
      // Test 2: ready toggling
      run_seq(1, 1'b0, 1'b0, 16);
      // Test 4: start pulsed while busy
      run_seq(1, 1'b1, 1'b0, 16);

      // Test 3: wrapping range 14..1
      @(posedge clk); #1 start_w = 1'b1;
      @(posedge clk); #1 start_w = 1'b0;
      budget = 0;
      while (done_w_cnt == 0 && budget < 200) begin
         @(posedge clk); #1;
         budget++;
      end
      repeat (4) @(posedge clk);
      #1;
      check("t3_done_count", 32'(done_w_cnt), 32'd1);
      check("t3_len", 32'(got_w.size()), 32'(model_len(14, 1)));
      check("t3_len_literal", 32'(got_w.size()), 32'd4);
      for (int i = 0; i < got_w.size(); i++) check("t3_byte", 32'(got_w[i]), 32'(model_byte(14, i)));
      if (got_w.size() == 4) begin
         check("t3_first_literal", 32'(got_w[0]), 32'hAE);
         check("t3_last_literal", 32'(got_w[3]), 32'hA1);
      end
      check("t3_busy_low", 32'(busy_w), 32'd0);

      // Test 5: reset while A5 sits in SEND
      for (int i = 0; i < 16; i++) exp_q.push_back(model_byte(0, i));
      xfer_cnt  = 0;
      check_gap = 1'b1;
      d0 = done_cnt;
      bus.out_ready = 1'b1;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      budget = 0;
      while (!(bus.out_valid && bus.out_data == 8'hA5) && budget < 200) begin
         @(posedge clk); #1;
         budget++;
      end
      bus.out_ready = 1'b0;
      check("t5_reached_a5", 32'(bus.out_data), 32'hA5);
      check("t5_sent_before", 32'(xfer_cnt), 32'd5);
      #2 rst_btn = 1'b0;
      #1;
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_done", 32'(done), 32'd0);
      check("t5_r_en", 32'(bus.r_en), 32'd0);
      check("t5_r_addr", 32'(bus.r_addr), 32'd0);
      check("t5_valid", 32'(bus.out_valid), 32'd0);
      check("t5_data", 32'(bus.out_data), 32'd0);
      repeat (3) @(posedge clk);
      #1 rst_btn = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("t5_no_done", 32'(done_cnt - d0), 32'd0);
      run_seq(0, 1'b0, 1'b0, 16);
      check("t5_replay_first", 32'(first_byte), 32'hA0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
